// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered decode stage for the logical instruction group with EX/MEM forwarding
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     pc_i,
  input  logic [31:0]           inst_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0]     reg1_data_i,
  input  logic [DATA_W-1:0]     reg2_data_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  flush_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     pc_o,
  output logic [7:0]            aluop_o,
  output logic [2:0]            alusel_o,
  output logic [DATA_W-1:0]     reg1_o,
  output logic [DATA_W-1:0]     reg2_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic                  illegal_o,
  output logic [CNT_W-1:0]      illegal_cnt_o
);

  localparam logic [7:0] ALU_NOP   = 8'h00;
  localparam logic [7:0] ALU_OR    = 8'h25;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;

  logic [5:0]            op;
  logic [4:0]            sa;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]     imm_zx;
  logic [DATA_W-1:0]     lui_val;

  assign op      = inst_i[31:26];
  assign sa      = inst_i[10:6];
  assign funct   = inst_i[5:0];
  assign rs_addr = REG_ADDR_W'(inst_i[25:21]);
  assign rt_addr = REG_ADDR_W'(inst_i[20:16]);
  assign rd_addr = REG_ADDR_W'(inst_i[15:11]);
  assign imm_zx  = {{(DATA_W-16){1'b0}}, inst_i[15:0]};
  assign lui_val = imm_zx << 16;

  // r0 reads as zero; EX is younger than MEM so it wins when both target the register
  function automatic logic [DATA_W-1:0] operand(input logic [REG_ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0]     rf_data);
    if (addr == '0)
      return '0;
    else if (FWD_EN != 0 && ex_wreg_i && ex_wd_i == addr)
      return ex_wdata_i;
    else if (FWD_EN != 0 && mem_wreg_i && mem_wd_i == addr)
      return mem_wdata_i;
    else
      return rf_data;
  endfunction

  logic                  dec_read1;
  logic                  dec_read2;
  logic [7:0]            dec_aluop;
  logic [2:0]            dec_alusel;
  logic [DATA_W-1:0]     dec_reg1;
  logic [DATA_W-1:0]     dec_reg2;
  logic [REG_ADDR_W-1:0] dec_wd;
  logic                  dec_wreg;
  logic                  dec_illegal;

  always_comb begin
    dec_read1   = 1'b0;
    dec_read2   = 1'b0;
    dec_aluop   = ALU_NOP;
    dec_alusel  = SEL_NOP;
    dec_reg1    = '0;
    dec_reg2    = '0;
    dec_wd      = '0;
    dec_wreg    = 1'b0;
    dec_illegal = 1'b0;
    case (op)
      6'b001100, 6'b001101, 6'b001110: begin
        // op[1:0] 00/01/10 maps onto AND/OR/XOR, which share the 8'h24 base
        dec_read1  = 1'b1;
        dec_aluop  = {6'b001001, op[1:0]};
        dec_alusel = SEL_LOGIC;
        dec_reg1   = operand(rs_addr, reg1_data_i);
        dec_reg2   = imm_zx;
        dec_wd     = rt_addr;
        dec_wreg   = 1'b1;
      end
      6'b001111: begin
        dec_aluop  = ALU_OR;
        dec_alusel = SEL_LOGIC;
        dec_reg1   = lui_val;
        dec_wd     = rt_addr;
        dec_wreg   = 1'b1;
      end
      6'b000000: begin
        if (inst_i == 32'h0) begin
          dec_illegal = 1'b0;
        end else if (sa == 5'd0 && funct[5:2] == 4'b1001) begin
          dec_read1  = 1'b1;
          dec_read2  = 1'b1;
          dec_aluop  = {2'b00, funct};
          dec_alusel = SEL_LOGIC;
          dec_reg1   = operand(rs_addr, reg1_data_i);
          dec_reg2   = operand(rt_addr, reg2_data_i);
          dec_wd     = rd_addr;
          dec_wreg   = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign reg1_read_o = dec_read1 && !rst;
  assign reg2_read_o = dec_read2 && !rst;
  assign reg1_addr_o = rst ? '0 : rs_addr;
  assign reg2_addr_o = rst ? '0 : rt_addr;

  logic capture;
  assign in_ready = !rst && !flush_i && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      pc_o          <= '0;
      aluop_o       <= ALU_NOP;
      alusel_o      <= SEL_NOP;
      reg1_o        <= '0;
      reg2_o        <= '0;
      wd_o          <= '0;
      wreg_o        <= 1'b0;
      illegal_o     <= 1'b0;
      illegal_cnt_o <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      pc_o      <= pc_i;
      aluop_o   <= dec_aluop;
      alusel_o  <= dec_alusel;
      reg1_o    <= dec_reg1;
      reg2_o    <= dec_reg2;
      wd_o      <= dec_wd;
      wreg_o    <= dec_wreg;
      illegal_o <= dec_illegal;
      if (dec_illegal && illegal_cnt_o != '1)
        illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - vector table plus handshake/flush/reset sequences for id_stage_pipe
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i;
  logic        out_ready;

  logic        in_ready, reg1_read_o, reg2_read_o, out_valid, wreg_o, illegal_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
  logic [31:0] pc_o, reg1_o, reg2_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [15:0] illegal_cnt_o;

  logic        s_in_ready, s_rd1, s_rd2, s_valid, s_wreg, s_ill;
  logic [4:0]  s_a1, s_a2, s_wd;
  logic [31:0] s_pc, s_r1, s_r2;
  logic [7:0]  s_aluop;
  logic [2:0]  s_sel;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  // narrow counter instance sharing all stimulus, used for the saturation check
  id_stage_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(s_rd1), .reg2_read_o(s_rd2), .reg1_addr_o(s_a1), .reg2_addr_o(s_a2),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid(s_valid), .out_ready(out_ready), .pc_o(s_pc),
    .aluop_o(s_aluop), .alusel_o(s_sel), .reg1_o(s_r1), .reg2_o(s_r2),
    .wd_o(s_wd), .wreg_o(s_wreg), .illegal_o(s_ill), .illegal_cnt_o(s_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rd1, rd2;
    logic        exw;
    logic [4:0]  exwd;
    logic [31:0] exdata;
    logic        memw;
    logic [4:0]  memwd;
    logic [31:0] memdata;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] op1, op2;
    logic [4:0]  wd;
    logic        wreg, ill, rden1, rden2;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sa, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, sa, funct};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd;
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{itype(6'h0d, 1, 2, 16'h00F0), 32'h0F00, 32'h0, 0, 0, 0, 0, 0, 0,
                 8'h25, 3'b001, 32'h0F00, 32'h000000F0, 2, 1, 0, 1, 0};
    vecs[1]  = '{itype(6'h0c, 5, 6, 16'hFFFF), 32'h12345678, 32'h0, 1, 6, 32'h1, 1, 5, 32'hCAFEBABE,
                 8'h24, 3'b001, 32'hCAFEBABE, 32'h0000FFFF, 6, 1, 0, 1, 0};
    vecs[2]  = '{itype(6'h0e, 0, 7, 16'h1234), 32'hFFFFFFFF, 32'h0, 1, 0, 32'hDEAD, 0, 0, 0,
                 8'h26, 3'b001, 32'h0, 32'h00001234, 7, 1, 0, 1, 0};
    vecs[3]  = '{rtype(3, 3, 4, 0, 6'h25), 32'h1111, 32'h2222, 1, 3, 32'hAAAA, 1, 3, 32'h5555,
                 8'h25, 3'b001, 32'hAAAA, 32'hAAAA, 4, 1, 0, 1, 1};
    vecs[4]  = '{rtype(0, 3, 4, 0, 6'h25), 32'h1111, 32'h2222, 1, 3, 32'hAAAA, 1, 3, 32'h5555,
                 8'h25, 3'b001, 32'h0, 32'hAAAA, 4, 1, 0, 1, 1};
    vecs[5]  = '{rtype(8, 9, 10, 0, 6'h24), 32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 0, 0,
                 8'h24, 3'b001, 32'hF0F0, 32'h0FF0, 10, 1, 0, 1, 1};
    vecs[6]  = '{rtype(1, 2, 31, 0, 6'h27), 32'h1, 32'h2, 0, 2, 32'h9999, 1, 2, 32'h7777,
                 8'h27, 3'b001, 32'h1, 32'h7777, 31, 1, 0, 1, 1};
    vecs[7]  = '{rtype(1, 2, 3, 1, 6'h26), 32'h1, 32'h2, 0, 0, 0, 0, 0, 0,
                 8'h00, 3'b000, 32'h0, 32'h0, 0, 0, 1, 0, 0};
    vecs[8]  = '{32'h0, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0,
                 8'h00, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0, 0};
    vecs[9]  = '{itype(6'h0f, 0, 3, 16'h1234), 32'h55, 32'h66, 0, 0, 0, 0, 0, 0,
                 8'h25, 3'b001, 32'h12340000, 32'h0, 3, 1, 0, 0, 0};
    vecs[10] = '{32'hFC000000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0,
                 8'h00, 3'b000, 32'h0, 32'h0, 0, 0, 1, 0, 0};

    rst = 1; in_valid = 0; pc_i = 0; inst_i = 0; reg1_data_i = 0; reg2_data_i = 0;
    flush_i = 0; out_ready = 1;
    clear_fwd();
    tick(); tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_aluop", aluop_o, 8'h00);
    chk("reset_cnt", illegal_cnt_o, 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      inst_i = vecs[i].inst; pc_i = 32'h100 + 4 * i; in_valid = 1; out_ready = 1;
      reg1_data_i = vecs[i].rd1; reg2_data_i = vecs[i].rd2;
      ex_wreg_i = vecs[i].exw; ex_wd_i = vecs[i].exwd; ex_wdata_i = vecs[i].exdata;
      mem_wreg_i = vecs[i].memw; mem_wd_i = vecs[i].memwd; mem_wdata_i = vecs[i].memdata;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      chk($sformatf("v%0d_read1", i), reg1_read_o, vecs[i].rden1);
      chk($sformatf("v%0d_read2", i), reg2_read_o, vecs[i].rden2);
      chk($sformatf("v%0d_addr1", i), reg1_addr_o, vecs[i].inst[25:21]);
      chk($sformatf("v%0d_addr2", i), reg2_addr_o, vecs[i].inst[20:16]);
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_pc", i), pc_o, 32'h100 + 4 * i);
      chk($sformatf("v%0d_aluop", i), aluop_o, vecs[i].aluop);
      chk($sformatf("v%0d_alusel", i), alusel_o, vecs[i].alusel);
      chk($sformatf("v%0d_reg1", i), reg1_o, vecs[i].op1);
      chk($sformatf("v%0d_reg2", i), reg2_o, vecs[i].op2);
      chk($sformatf("v%0d_wd", i), wd_o, vecs[i].wd);
      chk($sformatf("v%0d_wreg", i), wreg_o, vecs[i].wreg);
      chk($sformatf("v%0d_illegal", i), illegal_o, vecs[i].ill);
    end
    chk("table_illegal_cnt", illegal_cnt_o, 2);
    chk("table_illegal_cnt_narrow", s_cnt, 2);
    clear_fwd();

    // backpressure: A captured, B must wait three stalled cycles then enter exactly once
    inst_i = itype(6'h0c, 1, 2, 16'h00AA); pc_i = 32'h200; reg1_data_i = 32'h1; in_valid = 1; out_ready = 1;
    tick();
    chk("bp_a_pc", pc_o, 32'h200);
    inst_i = itype(6'h0e, 1, 2, 16'h00BB); pc_i = 32'h204; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_pc", pc_o, 32'h200);
      chk("bp_hold_aluop", aluop_o, 8'h24);
      chk("bp_hold_reg2", reg2_o, 32'h000000AA);
    end
    out_ready = 1;
    #1;
    chk("bp_in_ready_high", in_ready, 1);
    tick();
    chk("bp_b_pc", pc_o, 32'h204);
    chk("bp_b_aluop", aluop_o, 8'h26);
    chk("bp_b_reg2", reg2_o, 32'h000000BB);
    in_valid = 0;
    tick();
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_no_dup_pc", pc_o, 32'h204);

    // flush with a held entry and a valid illegal input
    inst_i = itype(6'h0d, 0, 1, 16'h0001); pc_i = 32'h300; in_valid = 1; out_ready = 0;
    tick();
    chk("fl_held_valid", out_valid, 1);
    flush_i = 1; inst_i = 32'hFC000000; pc_i = 32'h304;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_cnt_unchanged", illegal_cnt_o, 2);
    flush_i = 0; out_ready = 1; inst_i = itype(6'h0e, 0, 1, 16'h0002); pc_i = 32'h308;
    tick();
    chk("fl_next_valid", out_valid, 1);
    chk("fl_next_pc", pc_o, 32'h308);
    chk("fl_next_aluop", aluop_o, 8'h26);
    chk("fl_next_cnt", illegal_cnt_o, 2);

    // reset in the middle of a stall
    out_ready = 0; inst_i = itype(6'h0c, 4, 5, 16'h0003); pc_i = 32'h30C;
    tick();
    chk("rs_stall_valid", out_valid, 1);
    chk("rs_stall_pc", pc_o, 32'h308);
    rst = 1;
    #1;
    chk("rs_read1_comb", reg1_read_o, 0);
    chk("rs_addr1_comb", reg1_addr_o, 0);
    chk("rs_addr2_comb", reg2_addr_o, 0);
    tick();
    chk("rs_valid", out_valid, 0);
    chk("rs_pc", pc_o, 0);
    chk("rs_aluop", aluop_o, 0);
    chk("rs_alusel", alusel_o, 0);
    chk("rs_reg1", reg1_o, 0);
    chk("rs_reg2", reg2_o, 0);
    chk("rs_wd", wd_o, 0);
    chk("rs_wreg", wreg_o, 0);
    chk("rs_illegal", illegal_o, 0);
    chk("rs_cnt", illegal_cnt_o, 0);
    rst = 0; out_ready = 1; inst_i = itype(6'h0f, 0, 9, 16'h1234); pc_i = 32'h400;
    tick();
    chk("rs_lui_valid", out_valid, 1);
    chk("rs_lui_reg1", reg1_o, 32'h12340000);
    chk("rs_lui_aluop", aluop_o, 8'h25);
    chk("rs_lui_wd", wd_o, 9);

    // five illegal captures: wide counter reaches 5, two-bit counter sticks at 3
    inst_i = 32'hFC000000;
    for (int k = 0; k < 5; k++) begin
      pc_i = 32'h500 + 4 * k;
      tick();
    end
    chk("sat_illegal_o", illegal_o, 1);
    chk("sat_wreg_o", wreg_o, 0);
    chk("sat_cnt_wide", illegal_cnt_o, 5);
    chk("sat_cnt_narrow", s_cnt, 3);
    in_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised instruction-decode stage between IF/ID and EX.
- Decodes the logical instruction group (I-type and SPECIAL R-type) and drives combinational regfile read ports.
- Resolves RAW hazards by forwarding from EX and MEM.
- Presents results through a valid/ready output register with flush, and counts illegal encodings.

Parameters:
- DATA_W, 32, datapath width; must be ≥ 32; immediates zero-extended to DATA_W.
- ADDR_W, 32, PC width.
- REG_ADDR_W, 5, register index width.
- FWD_EN, 1, 1 = EX/MEM forwarding active; 0 = regfile data only.
- CNT_W, 16, illegal-instruction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage accepts input this cycle
- pc_i  in  ADDR_W  instruction PC
- inst_i  in  32  instruction word
- reg1_read_o, reg2_read_o  out  1 each  regfile read enables (combinational)
- reg1_addr_o, reg2_addr_o  out  REG_ADDR_W each  regfile read addresses (combinational)
- reg1_data_i, reg2_data_i  in  DATA_W each  regfile read data, same cycle
- ex_wreg_i / ex_wd_i / ex_wdata_i  in  1 / REG_ADDR_W / DATA_W  EX-stage writeback
- mem_wreg_i / mem_wd_i / mem_wdata_i  in  1 / REG_ADDR_W / DATA_W  MEM-stage writeback
- flush_i  in  1  discard held and incoming instruction
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  EX accepts output
- pc_o  out  ADDR_W  registered PC
- aluop_o  out  8  ALU op
- alusel_o  out  3  result select
- reg1_o, reg2_o  out  DATA_W each  operands
- wd_o  out  REG_ADDR_W  destination register
- wreg_o  out  1  write enable
- illegal_o  out  1  registered entry was an illegal encoding
- illegal_cnt_o  out  CNT_W  saturating illegal count

Behaviour:
- Fields: op=inst[31:26], rs=inst[25:21], rt=inst[20:16], rd=inst[15:11], sa=inst[10:6], funct=inst[5:0].
- Codes: aluop NOP 8'h00, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27. alusel NOP 3'b000, LOGIC 3'b001.
- ANDI 001100 / ORI 001101 / XORI 001110:
  - reg1=rs (read1=1), reg2={0,inst[15:0]} (read2=0), wd=rt, wreg=1, alusel LOGIC.
- LUI 001111:
  - read1=read2=0, reg1={0,inst[15:0],16'h0}, reg2=0, aluop OR, wd=rt, wreg=1.
- SPECIAL 000000 with sa==0 and funct 100100/100101/100110/100111 (AND/OR/XOR/NOR):
  - reg1=rs, reg2=rt, both reads=1, wd=rd, wreg=1.
- inst==32'h0: legal NOP, aluop/alusel NOP, wreg=0.
- Anything else is illegal:
  - NOP fields, wreg=0, illegal_o=1 in that entry.
  - Counter +1 on capture, saturating at 2^CNT_W-1.
- Read addresses track inst_i combinationally (rs, rt) regardless of in_valid.
- Operand source for a read port, priority:
  1. Address 0 → 0, never forwarded.
  2. FWD_EN && ex_wreg_i && ex_wd_i==addr → ex_wdata_i.
  3. FWD_EN && mem_wreg_i && mem_wd_i==addr → mem_wdata_i.
  4. Otherwise regfile data.
- Handshake:
  - in_ready = !out_valid || out_ready; forced 0 while rst or flush_i.
  - Capture on in_valid && in_ready: all outputs registered, 1-cycle latency, out_valid←1.
  - Output accepted, no new capture → out_valid←0.
  - Held outputs are stable while out_valid && !out_ready.
- flush_i (priority over capture): out_valid←0 next edge; the same-cycle input is dropped and not counted.
- Reset (at any time, incl. mid-stall):
  - Registered outputs: out_valid=0, pc_o=0, aluop NOP, alusel NOP, reg1_o=reg2_o=0, wd_o=0, wreg_o=0, illegal_o=0, illegal_cnt_o=0.
  - Combinational outputs: read enables=0, read addresses=0.

Test Plan:
- ORI rs=1 rt=2 imm=16'h00F0, reg1_data=32'h0F00, out_ready=1 → next cycle out_valid=1, aluop 25, reg1_o=0F00, reg2_o=000000F0, wd_o=2, wreg_o=1.
- Forwarding: R-type OR rs=3 rt=3 rd=4, ex_wd=3 data 32'hAAAA and mem_wd=3 data 32'h5555 both write → reg1_o=reg2_o=AAAA. Same with rs=0 → reg1_o=0.
- Backpressure: out_ready=0 for 3 cycles after capture → in_ready=0, outputs unchanged. out_ready=1 → next instruction captured the following edge, no loss or duplication.
- Illegal: inst=32'hFC000000 twice → illegal_o=1, wreg_o=0, illegal_cnt_o=2. CNT_W=2, 5 illegals → count saturates at 3.
- Flush with in_valid=1 and a held entry → out_valid=0 next cycle, counter unchanged, next valid instruction captured normally.
- Reset asserted while out_valid=1 and out_ready=0 → all registered outputs at reset values after one edge; LUI imm 16'h1234 after reset → reg1_o=32'h12340000, aluop 25.
